// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter.
// A one-entry holding register accepts bytes over a valid/ready handshake while
// the current frame is shifted out LSB-first, so consecutive bytes go out
// back-to-back with no idle time between the stop bit and the next start bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_TX_Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_State;
  logic [CNT_W-1:0] r_Clk_Count;
  logic [2:0]       r_Bit_Index;
  logic [7:0]       r_Shift;
  logic [7:0]       r_Hold;
  logic             r_Hold_Full;

  // The holding register being empty is exactly what "ready" means.
  assign o_TX_Ready = ~r_Hold_Full;

  // Holding register, bit timing and frame sequencing in one registered block.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State     <= S_IDLE;
      r_Clk_Count <= '0;
      r_Bit_Index <= '0;
      r_Shift     <= '0;
      r_Hold      <= '0;
      r_Hold_Full <= 1'b0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;

      if (i_TX_DV && !r_Hold_Full) begin
        r_Hold      <= i_TX_Byte;
        r_Hold_Full <= 1'b1;
      end

      case (r_State)
        S_IDLE: begin
          r_Clk_Count <= '0;
          r_Bit_Index <= '0;
          o_TX_Serial <= 1'b1;
          if (r_Hold_Full) begin
            r_Shift     <= r_Hold;
            r_Hold_Full <= 1'b0;
            o_TX_Serial <= 1'b0;
            o_TX_Active <= 1'b1;
            r_State     <= S_START;
          end else begin
            o_TX_Active <= 1'b0;
          end
        end

        S_START: begin
          if (r_Clk_Count == LAST_CNT) begin
            r_Clk_Count <= '0;
            r_Bit_Index <= '0;
            o_TX_Serial <= r_Shift[0];
            r_State     <= S_DATA;
          end else begin
            r_Clk_Count <= r_Clk_Count + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (r_Clk_Count == LAST_CNT) begin
            r_Clk_Count <= '0;
            if (r_Bit_Index == 3'd7) begin
              o_TX_Serial <= 1'b1;
              r_State     <= S_STOP;
            end else begin
              r_Bit_Index <= r_Bit_Index + 3'd1;
              o_TX_Serial <= r_Shift[r_Bit_Index + 3'd1];
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (r_Clk_Count == LAST_CNT) begin
            r_Clk_Count <= '0;
            r_Bit_Index <= '0;
            o_TX_Done   <= 1'b1;
            if (r_Hold_Full) begin
              r_Shift     <= r_Hold;
              r_Hold_Full <= 1'b0;
              o_TX_Serial <= 1'b0;
              r_State     <= S_START;
            end else begin
              o_TX_Serial <= 1'b1;
              o_TX_Active <= 1'b0;
              r_State     <= S_IDLE;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + CNT_W'(1);
          end
        end

        default: begin
          r_State     <= S_IDLE;
          o_TX_Serial <= 1'b1;
          o_TX_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// A line decoder behaves like a UART receiver sampling mid-bit; bytes it
// recovers are matched against a scoreboard of bytes handed to the transmitter.
module tb_uart_tx;

  localparam int C = 217;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready;
  logic       serial;
  logic       active;
  logic       done;

  int checks_total = 0;
  int checks_passed = 0;

  logic [7:0] sb[$];
  logic [7:0] rx_q[$];

  logic       mon_busy = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_shift = 8'h00;
  int         rx_frames = 0;
  int         frame_errors = 0;
  int         done_count = 0;

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_TX_DV    (dv),
    .i_TX_Byte  (data),
    .o_TX_Ready (ready),
    .o_TX_Serial(serial),
    .o_TX_Active(active),
    .o_TX_Done  (done)
  );

  // 40 ns system clock.
  always #20 clk = ~clk;

  // Receiver model: detect the start edge, sample each bit at its centre.
  always @(negedge clk) begin
    if (rst) begin
      mon_busy <= 1'b0;
      mon_cnt  <= 0;
    end else if (!mon_busy) begin
      if (serial === 1'b0) begin
        mon_busy <= 1'b1;
        mon_cnt  <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt % C == C / 2) begin
        if (mon_cnt / C == 0) begin
          if (serial !== 1'b0) begin
            mon_busy     <= 1'b0;
            frame_errors <= frame_errors + 1;
          end
        end else if (mon_cnt / C <= 8) begin
          mon_shift <= {serial, mon_shift[7:1]};
        end else begin
          if (serial === 1'b1) begin
            rx_q.push_back(mon_shift);
            rx_frames <= rx_frames + 1;
          end else begin
            frame_errors <= frame_errors + 1;
          end
          mon_busy <= 1'b0;
        end
      end
    end
  end

  // Count every cycle the done pulse is seen.
  always @(negedge clk) begin
    if (done === 1'b1) done_count <= done_count + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (ready !== 1'b1 && n < 3 * 10 * C) begin
      @(posedge clk); #1;
      n++;
    end
    dv = 1'b1;
    data = b;
    sb.push_back(b);
    @(posedge clk); #1;
    dv = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int c = 0;
    while ((rx_q.size() < n || mon_busy) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    ok = (rx_q.size() >= n) && !mon_busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks_total++;
    if (serial !== 1'b1) $display("[TB] FAIL reset_serial: got %b expected 1", serial);
    else checks_passed++;
    checks_total++;
    if (ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", ready);
    else checks_passed++;
    checks_total++;
    if (active !== 1'b0) $display("[TB] FAIL reset_active: got %b expected 0", active);
    else checks_passed++;
    checks_total++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done);
    else checks_passed++;
    rst = 1'b0;
  endtask

  task automatic test_idle;
    int ser_err = 0;
    int act_err = 0;
    int done_err = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (serial !== 1'b1) ser_err++;
      if (active !== 1'b0) act_err++;
      if (done !== 1'b0) done_err++;
    end
    checks_total++;
    if (ser_err != 0) $display("[TB] FAIL idle_serial: %0d cycles not high, expected 0", ser_err);
    else checks_passed++;
    checks_total++;
    if (act_err != 0) $display("[TB] FAIL idle_active: %0d cycles active, expected 0", act_err);
    else checks_passed++;
    checks_total++;
    if (done_err != 0) $display("[TB] FAIL idle_done: %0d done cycles, expected 0", done_err);
    else checks_passed++;
  endtask

  task automatic test_single_byte;
    logic [9:0] frame = {1'b1, 8'h37, 1'b0};
    int line_err = 0;
    int act_err = 0;
    int done_err = 0;
    bit ok;
    logic [7:0] got;
    logic [7:0] exp;
    @(posedge clk); #1;
    dv = 1'b1;
    data = 8'h37;
    sb.push_back(8'h37);
    @(posedge clk); #1;
    dv = 1'b0;
    checks_total++;
    if (ready !== 1'b0) $display("[TB] FAIL single_ready_after_load: got %b expected 0", ready);
    else checks_passed++;
    checks_total++;
    if (serial !== 1'b1) $display("[TB] FAIL single_latency: got %b expected 1 before start", serial);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (ready !== 1'b1) $display("[TB] FAIL single_ready_after_move: got %b expected 1", ready);
    else checks_passed++;
    for (int i = 0; i < 10 * C; i++) begin
      if (serial !== frame[i / C]) line_err++;
      if (active !== 1'b1) act_err++;
      if (done !== 1'b0) done_err++;
      @(posedge clk); #1;
    end
    checks_total++;
    if (line_err != 0) $display("[TB] FAIL single_line: %0d wrong cycles, expected 0", line_err);
    else checks_passed++;
    checks_total++;
    if (act_err != 0) $display("[TB] FAIL single_active: %0d inactive cycles, expected 0", act_err);
    else checks_passed++;
    checks_total++;
    if (done_err != 0) $display("[TB] FAIL single_early_done: %0d done cycles, expected 0", done_err);
    else checks_passed++;
    checks_total++;
    if (done !== 1'b1) $display("[TB] FAIL single_done_pulse: got %b expected 1", done);
    else checks_passed++;
    checks_total++;
    if (active !== 1'b0) $display("[TB] FAIL single_active_end: got %b expected 0", active);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (done !== 1'b0) $display("[TB] FAIL single_done_width: got %b expected 0", done);
    else checks_passed++;
    wait_rx(1, 3 * C, ok);
    checks_total++;
    if (!ok) $display("[TB] FAIL single_rx_timeout: got %0d bytes expected 1", rx_q.size());
    else checks_passed++;
    if (ok) begin
      got = rx_q.pop_front();
      exp = sb.pop_front();
      checks_total++;
      if (got !== exp) $display("[TB] FAIL single_byte: got %h expected %h", got, exp);
      else checks_passed++;
    end
  endtask

  task automatic test_back_to_back;
    int ready_err = 0;
    int act_err = 0;
    int pulses = 0;
    bit ok;
    logic [7:0] got;
    logic [7:0] exp;
    @(posedge clk); #1;
    dv = 1'b1;
    data = 8'h37;
    sb.push_back(8'h37);
    @(posedge clk); #1;
    dv = 1'b0;
    @(posedge clk); #1;
    checks_total++;
    if (serial !== 1'b0) $display("[TB] FAIL b2b_first_start: got %b expected 0", serial);
    else checks_passed++;
    dv = 1'b1;
    data = 8'hA5;
    sb.push_back(8'hA5);
    @(posedge clk); #1;
    dv = 1'b0;
    for (int i = 1; i <= 2 * 10 * C; i++) begin
      if (i < 10 * C && ready !== 1'b0) ready_err++;
      if (i < 2 * 10 * C && active !== 1'b1) act_err++;
      if (done === 1'b1) pulses++;
      if (i == 10 * C) begin
        checks_total++;
        if (serial !== 1'b0) $display("[TB] FAIL b2b_no_gap: got %b expected 0", serial);
        else checks_passed++;
        checks_total++;
        if (ready !== 1'b1) $display("[TB] FAIL b2b_ready_release: got %b expected 1", ready);
        else checks_passed++;
      end
      if (i == 2 * 10 * C) begin
        checks_total++;
        if (active !== 1'b0) $display("[TB] FAIL b2b_active_end: got %b expected 0", active);
        else checks_passed++;
      end
      if (i < 2 * 10 * C) begin
        @(posedge clk); #1;
      end
    end
    checks_total++;
    if (ready_err != 0) $display("[TB] FAIL b2b_ready_held: %0d ready cycles, expected 0", ready_err);
    else checks_passed++;
    checks_total++;
    if (act_err != 0) $display("[TB] FAIL b2b_active: %0d gaps, expected 0", act_err);
    else checks_passed++;
    checks_total++;
    if (pulses != 2) $display("[TB] FAIL b2b_done_count: got %0d expected 2", pulses);
    else checks_passed++;
    wait_rx(2, 3 * C, ok);
    checks_total++;
    if (!ok) $display("[TB] FAIL b2b_rx_timeout: got %0d bytes expected 2", rx_q.size());
    else checks_passed++;
    while (ok && rx_q.size() > 0 && sb.size() > 0) begin
      got = rx_q.pop_front();
      exp = sb.pop_front();
      checks_total++;
      if (got !== exp) $display("[TB] FAIL b2b_byte: got %h expected %h", got, exp);
      else checks_passed++;
    end
  endtask

  task automatic test_overflow;
    int ready_err = 0;
    bit ok;
    logic [7:0] got;
    logic [7:0] exp;
    @(posedge clk); #1;
    dv = 1'b1;
    data = 8'h37;
    sb.push_back(8'h37);
    @(posedge clk); #1;
    dv = 1'b0;
    @(posedge clk); #1;
    dv = 1'b1;
    data = 8'hA5;
    sb.push_back(8'hA5);
    @(posedge clk); #1;
    data = 8'h11;
    for (int i = 0; i < 50; i++) begin
      if (ready !== 1'b0) ready_err++;
      @(posedge clk); #1;
    end
    dv = 1'b0;
    checks_total++;
    if (ready_err != 0) $display("[TB] FAIL overflow_ready: %0d ready cycles, expected 0", ready_err);
    else checks_passed++;
    wait_rx(2, 6000, ok);
    checks_total++;
    if (!ok) $display("[TB] FAIL overflow_rx_timeout: got %0d bytes expected 2", rx_q.size());
    else checks_passed++;
    while (ok && rx_q.size() > 0 && sb.size() > 0) begin
      got = rx_q.pop_front();
      exp = sb.pop_front();
      checks_total++;
      if (got !== exp) $display("[TB] FAIL overflow_byte: got %h expected %h", got, exp);
      else checks_passed++;
    end
    repeat (3 * C) @(posedge clk);
    #1;
    checks_total++;
    if (rx_q.size() != 0) $display("[TB] FAIL overflow_extra: got %0d extra bytes expected 0", rx_q.size());
    else checks_passed++;
  endtask

  task automatic test_reset_mid;
    int ser_err = 0;
    int done_err = 0;
    bit ok;
    logic [7:0] got;
    logic [7:0] exp;
    @(posedge clk); #1;
    dv = 1'b1;
    data = 8'h37;
    sb.push_back(8'h37);
    @(posedge clk); #1;
    dv = 1'b0;
    @(posedge clk); #1;
    dv = 1'b1;
    data = 8'hC3;
    sb.push_back(8'hC3);
    @(posedge clk); #1;
    dv = 1'b0;
    repeat (4 * C + 99) @(posedge clk);
    #1;
    checks_total++;
    if (serial !== 1'b0) $display("[TB] FAIL midreset_bit3: got %b expected 0", serial);
    else checks_passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    checks_total++;
    if (serial !== 1'b1) $display("[TB] FAIL midreset_serial: got %b expected 1", serial);
    else checks_passed++;
    checks_total++;
    if (ready !== 1'b1) $display("[TB] FAIL midreset_ready: got %b expected 1", ready);
    else checks_passed++;
    checks_total++;
    if (active !== 1'b0) $display("[TB] FAIL midreset_active: got %b expected 0", active);
    else checks_passed++;
    for (int i = 0; i < 12 * C; i++) begin
      if (serial !== 1'b1) ser_err++;
      if (done !== 1'b0) done_err++;
      @(posedge clk); #1;
    end
    checks_total++;
    if (ser_err != 0) $display("[TB] FAIL midreset_discard: %0d low cycles, expected 0", ser_err);
    else checks_passed++;
    checks_total++;
    if (done_err != 0) $display("[TB] FAIL midreset_done: %0d done cycles, expected 0", done_err);
    else checks_passed++;
    checks_total++;
    if (rx_q.size() != 0) $display("[TB] FAIL midreset_rx: got %0d bytes expected 0", rx_q.size());
    else checks_passed++;
    send_byte(8'h55);
    wait_rx(1, 3 * 10 * C, ok);
    checks_total++;
    if (!ok) $display("[TB] FAIL midreset_rx_timeout: got %0d bytes expected 1", rx_q.size());
    else checks_passed++;
    if (ok) begin
      got = rx_q.pop_front();
      exp = sb.pop_front();
      checks_total++;
      if (got !== exp) $display("[TB] FAIL midreset_next_byte: got %h expected %h", got, exp);
      else checks_passed++;
    end
  endtask

  task automatic test_loopback;
    int frames0;
    int done0;
    bit ok;
    logic [7:0] got;
    logic [7:0] exp;
    repeat (2 * C) @(posedge clk);
    #1;
    frames0 = rx_frames;
    done0 = done_count;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h37);
    wait_rx(3, 5 * 10 * C, ok);
    checks_total++;
    if (!ok) $display("[TB] FAIL loopback_rx_timeout: got %0d bytes expected 3", rx_q.size());
    else checks_passed++;
    while (ok && rx_q.size() > 0 && sb.size() > 0) begin
      got = rx_q.pop_front();
      exp = sb.pop_front();
      checks_total++;
      if (got !== exp) $display("[TB] FAIL loopback_byte: got %h expected %h", got, exp);
      else checks_passed++;
    end
    repeat (2 * C) @(posedge clk);
    #1;
    checks_total++;
    if (rx_frames - frames0 != 3) $display("[TB] FAIL loopback_frames: got %0d expected 3", rx_frames - frames0);
    else checks_passed++;
    checks_total++;
    if (done_count - done0 != 3) $display("[TB] FAIL loopback_done: got %0d expected 3", done_count - done0);
    else checks_passed++;
    checks_total++;
    if (frame_errors != 0) $display("[TB] FAIL framing: got %0d errors expected 0", frame_errors);
    else checks_passed++;
  endtask

  // Run every scenario in order, then report.
  initial begin
    $display("[TB] uart_tx bench starting");
    test_reset();
    test_idle();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_loopback();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
